// File: rtl/mmio_result_checker.sv
// Watches CPU writes to a single result port, frames a test between BEGIN_SYM and
// END_SYM/limit, and compares each result word against a preloaded expected table.
module mmio_result_checker #(
  parameter int unsigned       ADDR_W     = 30,
  parameter logic [ADDR_W-1:0] TEST_PORT  = 'h10,
  parameter logic [31:0]       BEGIN_SYM  = 32'h00000168,
  parameter logic [31:0]       END_SYM    = 32'hFFFFFD5D,
  parameter int unsigned       DEPTH      = 32,
  parameter int unsigned       DUR_W      = 16,
  parameter int unsigned       TIMEOUT    = int'((64'd1 << DUR_W) - 64'd1),
  parameter bit                SWAP_BYTES = 1'b1,
  localparam int unsigned      IW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  input  logic              wen,
  input  logic              exp_we,
  input  logic [IW-1:0]     exp_idx,
  input  logic [31:0]       exp_data,
  input  logic [IW:0]       check_num,
  output logic [7:0]        error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              pass,
  output logic              timeout,
  output logic [IW-1:0]     first_err_idx,
  output logic [31:0]       first_err_data,
  output logic              first_err_vld
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(TIMEOUT - 1);
  localparam logic [IW:0]      LIM_MAX  = (IW+1)'(DEPTH);

  logic [1:0]       state;
  logic             prev_wen;
  logic [IW-1:0]    idx;
  logic [IW:0]      limit;
  logic [IW:0]      limit_in;
  logic [7:0]       err_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             tmo;
  logic [IW-1:0]    fe_idx;
  logic [31:0]      fe_data;
  logic             fe_vld;
  logic [31:0]      dm;
  logic             wr_evt;
  logic             mismatch;
  logic             last_word;
  logic             early_end;
  logic             dur_hit;

  logic [31:0] tbl [DEPTH];

  always_comb begin
    dm = data;
    if (SWAP_BYTES) dm = {data[7:0], data[15:8], data[23:16], data[31:24]};
  end

  // Rising-edge detect on wen so a write held for several cycles is one event.
  assign wr_evt    = (addr == TEST_PORT) && wen && !prev_wen;
  assign mismatch  = (dm != tbl[idx]);
  assign last_word = ({1'b0, idx} == (limit - (IW+1)'(1)));
  assign early_end = (dm == END_SYM);
  assign dur_hit   = (dur_cnt == DUR_LAST);

  always_comb begin
    limit_in = check_num;
    if (check_num == '0)          limit_in = (IW+1)'(1);
    else if (check_num > LIM_MAX) limit_in = LIM_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst && exp_we && (state == S_IDLE)) tbl[exp_idx] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      prev_wen <= 1'b0;
      idx      <= '0;
      limit    <= (IW+1)'(1);
      err_cnt  <= '1;
      dur_cnt  <= '0;
      tmo      <= 1'b0;
      fe_idx   <= '0;
      fe_data  <= '0;
      fe_vld   <= 1'b0;
    end else begin
      prev_wen <= wen;
      case (state)
        S_IDLE: begin
          if (wr_evt && (dm == BEGIN_SYM)) begin
            state   <= S_CHECK;
            err_cnt <= '0;
            limit   <= limit_in;
          end
        end
        S_CHECK: begin
          dur_cnt <= dur_cnt + DUR_W'(1);
          if (wr_evt) begin
            idx <= idx + IW'(1);
            if (mismatch) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
              if (!fe_vld) begin
                fe_vld  <= 1'b1;
                fe_idx  <= idx;
                fe_data <= dm;
              end
            end
          end
          // A terminating write wins over the timeout in the same cycle.
          if (wr_evt && (last_word || early_end)) begin
            state <= S_REPORT;
          end else if (dur_hit) begin
            state <= S_REPORT;
            tmo   <= 1'b1;
          end
        end
        S_REPORT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign error_num      = err_cnt;
  assign duration       = dur_cnt;
  assign finish         = (state == S_REPORT);
  assign pass           = finish && (err_cnt == '0) && !tmo;
  assign timeout        = tmo;
  assign first_err_idx  = fe_idx;
  assign first_err_data = fe_data;
  assign first_err_vld  = fe_vld;

endmodule

// File: tb/tb_mmio_result_checker.sv
// Randomized bench for mmio_result_checker; expected results come from a
// transaction-level model of the test framing rules.
module tb_mmio_result_checker;

  localparam int          DEPTH = 32;
  localparam int          IW    = 5;
  localparam int          TMO   = 100;
  localparam logic [29:0] PORT  = 30'h10;
  localparam logic [31:0] BSYM  = 32'h00000168;
  localparam logic [31:0] ESYM  = 32'hFFFFFD5D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [29:0]   addr = '0;
  logic [31:0]   data = '0;
  logic          wen = 1'b0;
  logic          exp_we = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [31:0]   exp_data = '0;
  logic [IW:0]   check_num = '0;
  logic [7:0]    error_num;
  logic [15:0]   duration;
  logic          finish, pass, timeout, first_err_vld;
  logic [IW-1:0] first_err_idx;
  logic [31:0]   first_err_data;

  mmio_result_checker #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .check_num(check_num),
    .error_num(error_num), .duration(duration), .finish(finish), .pass(pass),
    .timeout(timeout), .first_err_idx(first_err_idx), .first_err_data(first_err_data),
    .first_err_vld(first_err_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] tbl_m [DEPTH];
  logic [31:0] wq [$];
  int          oq [$];
  int          b_cyc;

  int          e_err, e_dur, e_fi;
  logic        e_tmo, e_fv, e_pass;
  logic [31:0] e_fd;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; wen = 1'b0; exp_we = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic load_entry(input int i, input logic [31:0] v);
    exp_we = 1'b1; exp_idx = IW'(i); exp_data = v;
    tick(1);
    exp_we = 1'b0;
    tbl_m[i] = v;
  endtask

  // ev is the cycle stamp of the clock edge that sees the rising wen.
  task automatic cpu_write(input logic [31:0] w, input int hold, input int gap,
                           input logic [29:0] a, output int ev);
    addr = a; data = bswap(w); wen = 1'b1; ev = cyc;
    tick(hold);
    wen = 1'b0;
    tick(gap);
  endtask

  task automatic start_run(input int cn);
    int ev;
    wq.delete(); oq.delete();
    check_num = (IW+1)'(cn);
    cpu_write(32'h12345678, 1, 1, PORT, ev);
    cpu_write(BSYM, 1, 1, PORT + 30'd1, ev);
    cpu_write(BSYM, 1, 1, PORT, b_cyc);
    // table writes while checking must have no effect
    exp_we = 1'b1; exp_idx = '0; exp_data = ~tbl_m[0];
    tick(1);
    exp_we = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int hold, input int gap);
    int ev;
    cpu_write(w, hold, gap, PORT, ev);
    wq.push_back(w);
    oq.push_back(ev - b_cyc);
  endtask

  function automatic void model(input int cn);
    int lim = (cn == 0) ? 1 : (cn > DEPTH ? DEPTH : cn);
    int idx = 0;
    bit done = 0;
    e_err = 0; e_fv = 0; e_fi = 0; e_fd = '0; e_tmo = 0; e_dur = TMO;
    foreach (wq[j]) begin
      if (done || oq[j] > TMO) break;
      if (wq[j] != tbl_m[idx]) begin
        if (e_err < 255) e_err++;
        if (!e_fv) begin e_fv = 1; e_fi = idx; e_fd = wq[j]; end
      end
      if (idx == lim - 1 || wq[j] == ESYM) begin done = 1; e_dur = oq[j]; end
      idx++;
    end
    if (!done) e_tmo = 1;
    e_pass = (e_err == 0) && !e_tmo;
  endfunction

  task automatic finish_and_check(input string tag, input int cn);
    int w = 0;
    while (!finish && w < TMO + 60) begin tick(1); w++; end
    model(cn);
    check_value({tag, ".finish"},  32'(finish), 32'd1);
    check_value({tag, ".err"},     32'(error_num), 32'(e_err));
    check_value({tag, ".dur"},     32'(duration), 32'(e_dur));
    check_value({tag, ".pass"},    32'(pass), 32'(e_pass));
    check_value({tag, ".tmo"},     32'(timeout), 32'(e_tmo));
    check_value({tag, ".fe_vld"},  32'(first_err_vld), 32'(e_fv));
    check_value({tag, ".fe_idx"},  32'(first_err_idx), 32'(e_fi));
    check_value({tag, ".fe_data"}, first_err_data, e_fd);
  endtask

  task automatic check_reset_vals(input string tag);
    check_value({tag, ".err"},    32'(error_num), 32'd255);
    check_value({tag, ".dur"},    32'(duration), 32'd0);
    check_value({tag, ".finish"}, 32'(finish), 32'd0);
    check_value({tag, ".pass"},   32'(pass), 32'd0);
    check_value({tag, ".tmo"},    32'(timeout), 32'd0);
    check_value({tag, ".fe_vld"}, 32'(first_err_vld), 32'd0);
    check_value({tag, ".fe_idx"}, 32'(first_err_idx), 32'd0);
    check_value({tag, ".fe_data"}, first_err_data, 32'd0);
  endtask

  task automatic load_19();
    for (int i = 0; i < 18; i++) load_entry(i, $urandom);
    load_entry(18, ESYM);
  endtask

  task automatic full_run(input string tag, input int bad_a, input int bad_b, input int hold);
    start_run(19);
    for (int i = 0; i < 19; i++)
      send_word((i == bad_a || i == bad_b) ? ~tbl_m[i] : tbl_m[i], hold, 1);
    finish_and_check(tag, 19);
  endtask

  initial begin
    tick(1);
    do_reset();
    check_reset_vals("reset");

    load_19();
    full_run("all_match", -1, -1, 1);
    check_value("all_match.pass_fixed", 32'(pass), 32'd1);

    do_reset(); load_19();
    full_run("corrupt_4_9", 4, 9, 1);
    check_value("corrupt_4_9.err_fixed", 32'(error_num), 32'd2);
    check_value("corrupt_4_9.idx_fixed", 32'(first_err_idx), 32'd4);

    do_reset(); load_19();
    full_run("held_wen", -1, -1, 3);
    check_value("held_wen.pass_fixed", 32'(pass), 32'd1);

    do_reset();
    start_run(19);
    finish_and_check("timeout", 19);
    check_value("timeout.dur_fixed", 32'(duration), 32'd100);

    do_reset(); load_19(); load_entry(5, ESYM);
    start_run(19);
    for (int i = 0; i < 6; i++) send_word(tbl_m[i], 1, 1);
    finish_and_check("early_end", 19);

    do_reset(); load_19();
    start_run(19);
    for (int i = 0; i < 5; i++) send_word(i == 2 ? ~tbl_m[i] : tbl_m[i], 1, 1);
    do_reset();
    check_reset_vals("mid_rst");
    full_run("rerun", -1, -1, 1);

    for (int r = 0; r < 8; r++) begin
      int cn, lim, nw;
      do_reset();
      for (int i = 0; i < DEPTH; i++) load_entry(i, $urandom);
      cn  = $urandom_range(40, 0);
      lim = (cn == 0) ? 1 : (cn > DEPTH ? DEPTH : cn);
      nw  = $urandom_range(lim + 1, 1);
      start_run(cn);
      for (int i = 0; i < nw; i++) begin
        logic [31:0] w;
        w = (i < DEPTH) ? tbl_m[i] : 32'h0;
        if ($urandom_range(9, 0) == 0) w = w ^ ($urandom | 32'd1);
        if ($urandom_range(29, 0) == 0) w = ESYM;
        send_word(w, $urandom_range(2, 1), $urandom_range(2, 1));
      end
      finish_and_check($sformatf("rand%0d", r), cn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_result_checker.md
MMIO_RESULT_CHECKER -- requirements
Module: mmio_result_checker

Interface
REQ-001 Parameter ADDR_W, default 30, width of the word address bus.
REQ-002 Parameter TEST_PORT, default 30'h10, word address monitored for result writes.
REQ-003 Parameter BEGIN_SYM, default 32'h00000168, start-of-test symbol.
REQ-004 Parameter END_SYM, default 32'hFFFFFD5D, end-of-test symbol.
REQ-005 Parameter DEPTH, default 32, expected-value table entries (power of two); IW = log2(DEPTH).
REQ-006 Parameter DUR_W, default 16, duration counter width.
REQ-007 Parameter TIMEOUT, default 2^DUR_W-1, CHECK-state cycle limit.
REQ-008 Parameter SWAP_BYTES, default 1, 1 = byte-reverse data (little-endian to readable).
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 addr  in  ADDR_W  CPU data-memory word address.
REQ-012 data  in  32  CPU write data.
REQ-013 wen  in  1  CPU write enable.
REQ-014 exp_we  in  1  expected-table write strobe.
REQ-015 exp_idx  in  IW  expected-table write index.
REQ-016 exp_data  in  32  expected-table write value.
REQ-017 check_num  in  IW+1  number of result writes to check, END_SYM included.
REQ-018 error_num  out  8  mismatch count; 255 while idle.
REQ-019 duration  out  DUR_W  cycles spent in CHECK.
REQ-020 finish  out  1  high in REPORT.
REQ-021 pass  out  1  finish and error_num==0 and timeout==0.
REQ-022 timeout  out  1  CHECK aborted by TIMEOUT.
REQ-023 first_err_idx  out  IW  index of first mismatch.
REQ-024 first_err_data  out  32  (swapped) data of first mismatch.
REQ-025 first_err_vld  out  1  first_err_* valid.

Function
REQ-026 dm SHALL be {data[7:0],data[15:8],data[23:16],data[31:24]} when SWAP_BYTES=1, else data.
REQ-027 A write event SHALL be addr==TEST_PORT, wen==1, and registered previous wen==0; wen held N cycles yields one event.
REQ-028 FSM states SHALL be IDLE, CHECK, REPORT; REPORT exits only via rst.
REQ-029 IDLE: error_num=255, duration=0, idx=0; event with dm==BEGIN_SYM SHALL enter CHECK next cycle with error_num=0; other events ignored.
REQ-030 On CHECK entry, limit SHALL latch check_num, clamped: 0 -> 1, >DEPTH -> DEPTH.
REQ-031 CHECK: duration SHALL increment every cycle, including the cycle that leaves CHECK.
REQ-032 CHECK event: dm compared to table[idx]; mismatch increments error_num, saturating at 255; idx increments.
REQ-033 First mismatch after CHECK entry SHALL capture idx and dm and set first_err_vld; later mismatches leave them unchanged.
REQ-034 Event with idx==limit-1 SHALL enter REPORT next cycle.
REQ-035 Event with dm==END_SYM and idx<limit-1 SHALL be compared normally, then enter REPORT (early end; unchecked entries not counted).
REQ-036 duration==TIMEOUT in CHECK with no terminating event SHALL enter REPORT with timeout=1; a terminating event that same cycle takes priority, timeout=0.
REQ-037 REPORT: all outputs frozen, finish=1, pass per REQ-021.
REQ-038 exp_we SHALL write table[exp_idx]=exp_data only in IDLE; ignored in CHECK/REPORT.
REQ-039 Table is read asynchronously by idx; contents are not cleared by rst.

Reset
REQ-040 rst=1 at a rising edge SHALL force IDLE, error_num=255, duration=0, idx=0, finish=0, pass=0, timeout=0, first_err_vld=0, first_err_idx=0, first_err_data=0, prev-wen=0, regardless of state; rst dominates all events.

Verification
REQ-041 Load 19 entries (last END_SYM), check_num=19, write BEGIN_SYM then 19 matching words -> finish=1, pass=1, error_num=0.
REQ-042 Same, words 4 and 9 corrupted -> error_num=2, first_err_idx=4, first_err_vld=1, pass=0.
REQ-043 wen held 3 cycles per write, SWAP_BYTES=1, byte-reversed data -> each write counted once, pass=1.
REQ-044 BEGIN_SYM, then no writes, TIMEOUT=100 -> REPORT with timeout=1, duration=100, pass=0.
REQ-045 END_SYM written at idx 5 with check_num=19, table[5]=END_SYM -> REPORT, error_num=0, pass=1.
REQ-046 rst pulsed mid-CHECK, then full rerun -> outputs back to reset values, second run passes with duration counted from zero.
